// File: rtl/display_pkg.sv
// Shared definitions for the display path: FSM encoding, BCD digit width,
// and elaboration-time helpers for sizing the converter.
package display_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int BCD_W = 4;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // True when DIGITS decimal digits can represent every WIDTH-bit value.
  function automatic bit digits_ok(input int width, input int digits);
    longint unsigned lim;
    longint unsigned p;
    lim = (64'd1 << width) - 64'd1;
    p   = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p > lim;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle,
// with a start/busy/done handshake and a held result register.
module bcd_convert_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd
);

  localparam int BW = BCD_W * DIGITS;
  localparam int WW = BW + WIDTH;
  localparam int CW = clog2_min1(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
      $error("bcd_convert_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [WW-1:0]   work_q, work_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [BW-1:0]   adj;
  logic [WW-1:0]   shifted;

  // BCD part lives above the binary part; every field is corrected in parallel.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_i (work_q[WIDTH + BCD_W*gi +: BCD_W]),
        .digit_o (adj[BCD_W*gi +: BCD_W])
      );
    end
  endgenerate

  assign shifted = {adj, work_q[WIDTH-1:0]} << 1;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = {{BW{1'b0}}, bin};
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d  = shifted;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          bcd_d   = shifted[WW-1 -: BW];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench for bcd_convert_seq: stimulus pushes expected results,
// a negedge monitor checks busy, done timing and decimal digits.
module tb_bcd_convert_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                 Clock;
  logic                 Resetn;
  logic                 start;
  logic [WIDTH-1:0]     bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;

  bcd_convert_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int v;
    int acc;
  } txn_t;

  txn_t sb[$];
  int   tests     = 0;
  int   fails     = 0;
  int   negcnt    = 0;
  int   pushes    = 0;
  int   discarded = 0;
  int   done_seen = 0;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic bit digits_valid(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compares everything visible on the falling edge.
  always @(negedge Clock) begin
    txn_t t;
    logic exp_busy;
    if (Resetn === 1'b1) begin
      exp_busy = (sb.size() > 0) && ((negcnt - sb[0].acc) < WIDTH);
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("digits_le_9", {31'd0, digits_valid(bcd)}, 32'd1);
      if (done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 bcd=%h expected no done", bcd);
        end else begin
          t = sb.pop_front();
          check("bcd", {20'd0, bcd}, {20'd0, ref_bcd(t.v)});
          check("latency", negcnt - t.acc, WIDTH);
          $display("[TB] bin=%0d bcd=%h expected=%h", t.v, bcd, ref_bcd(t.v));
        end
      end else if (sb.size() > 0 && (negcnt - sb[0].acc) > WIDTH) begin
        t = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_done: bin=%0d got no done expected done at latency %0d", t.v, WIDTH);
      end
    end
    negcnt++;
  end

  task automatic push_txn(input int v);
    txn_t t;
    t.v   = v;
    t.acc = negcnt;
    sb.push_back(t);
    pushes++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge Clock);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      discarded += sb.size();
      sb.delete();
    end
  endtask

  task automatic convert(input int v, input int gap);
    @(negedge Clock);
    bin   = WIDTH'(v);
    start = 1'b1;
    @(posedge Clock);
    push_txn(v);
    @(negedge Clock);
    start = 1'b0;
    bin   = WIDTH'($urandom);
    wait_drain();
    repeat (gap) @(negedge Clock);
  endtask

  initial begin
    Resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {20'd0, bcd}, 32'd0);
    #10;
    Resetn = 1'b1;

    convert(0, 1);
    convert(255, 0);
    convert(99, 0);
    convert(10, 2);

    // start pulse while busy must be ignored
    @(negedge Clock);
    bin   = 8'd128;
    start = 1'b1;
    @(posedge Clock);
    push_txn(128);
    @(negedge Clock);
    start = 1'b0;
    bin   = 8'd7;
    repeat (2) @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge Clock);

    // asynchronous reset in the middle of a conversion
    @(negedge Clock);
    bin   = 8'd200;
    start = 1'b1;
    @(posedge Clock);
    push_txn(200);
    @(negedge Clock);
    start = 1'b0;
    repeat (4) @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_bcd", {20'd0, bcd}, 32'd0);
    discarded += sb.size();
    sb.delete();
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
    repeat (15) @(negedge Clock);

    // start held high: back-to-back accepts every WIDTH+1 cycles
    @(negedge Clock);
    bin   = 8'd1;
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge Clock);
      push_txn(i);
      repeat (WIDTH + 1) @(negedge Clock);
      bin = WIDTH'(i + 1);
    end
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge Clock);

    for (int v = 0; v < 256; v++) convert(v, 0);
    for (int k = 0; k < 30; k++) convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    repeat (12) @(negedge Clock);
    check("done_count", done_seen, pushes - discarded);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
